axil_cmd_master: RTL and testbench
==================================

// Module: axil_cmd_master
// PURPOSE
//  AXI-Lite initiator. Converts a simple command stream (addr, data, write flag)
//  into single AXI-Lite read or write transactions. Returns each completion on a
//  response stream. Sits between a host-side controller or testbench driver and
//  any AXI-Lite register slave. Only one transaction is outstanding at a time.
// PARAMETERS
//  CFGAW     32  address width, cmd_addr and axil addr channels
//  CFGDW     32  data width, cmd_data, rsp_data and axil data channels
//  ERRCW     8   width of the saturating error counter
// PORTS
//  clk             in   1      clock
//  rst             in   1      sync reset, active high
//  cmd_addr        in   CFGAW  target address
//  cmd_data        in   CFGDW  write data (ignored for reads)
//  cmd_we          in   1      1=write, 0=read
//  cmd_valid       in   1      command valid
//  cmd_ready       out  1      command accepted when valid&&ready
//  rsp_data        out  CFGDW  read data (0 for writes)
//  rsp_resp        out  2      bresp/rresp of the completed transaction
//  rsp_we          out  1      echo of the command's cmd_we
//  rsp_valid       out  1      response valid
//  rsp_ready       in   1      response consumed when valid&&ready
//  m_axil_aw*      out  awaddr[CFGAW], awvalid; in awready
//  m_axil_w*       out  wdata[CFGDW], wvalid;   in wready
//  m_axil_b*       in   bresp[2], bvalid;       out bready
//  m_axil_ar*      out  araddr[CFGAW], arvalid; in arready
//  m_axil_r*       in   rdata[CFGDW], rresp[2], rvalid; out rready
//  err_count       out  ERRCW  count of completions with resp!=0, saturating
// BEHAVIOUR
//  States: IDLE, WR, WB, RA, RD, RSP. Registered outputs throughout.
//  IDLE:
//   - cmd_ready=1 only in IDLE.
//   - On accept, latch addr, data and we. Go to WR if we=1, else RA.
//  WR:
//   - awvalid and wvalid both rise the cycle after accept (latency 1).
//   - Each drops the cycle after its own handshake. aw_done and w_done are
//     tracked independently.
//   - When both are done, go to WB. If both handshakes occur in the same cycle,
//     go to WB on the next cycle.
//  WB:
//   - bready=1.
//   - On bvalid, capture bresp into rsp_resp, set rsp_data=0, go to RSP.
//  RA:
//   - arvalid=1 until arready, then go to RD.
//  RD:
//   - rready=1.
//   - On rvalid, capture rdata and rresp, go to RSP.
//  RSP:
//   - rsp_valid=1. rsp_data, rsp_resp and rsp_we are held stable until
//     rsp_ready.
//   - Then go to IDLE. cmd_ready=1 the following cycle.
//  General rules:
//   - AXI valids never deassert before their handshake.
//   - awaddr, wdata and araddr are stable while their valid is high.
//   - bready and rready are high only in WB and RD.
//   - Beats on bvalid or rvalid outside WB or RD are not expected and are
//     ignored.
//   - err_count increments on entry to RSP when resp!=0. It holds at
//     2**ERRCW-1 and never wraps.
//  Reset:
//   - state=IDLE.
//   - awvalid, wvalid, arvalid, bready, rready, rsp_valid = 0.
//   - rsp_data=0, rsp_resp=0, rsp_we=0, err_count=0.
//   - All address and data outputs = 0.
//   - Reset mid-transaction abandons it and produces no response. The slave
//     shares rst.
// TESTING
//  1. Write addr=3, data=0x1234, all slave readies=1
//     -> awvalid=wvalid=1 at accept+1, bready at accept+2,
//        rsp_valid with we=1, resp=0, data=0.
//  2. Write with awready delayed 3 cycles, wready=1
//     -> wvalid high 1 cycle, awvalid high 4 cycles, exactly one bready window,
//        one response.
//  3. Read addr=33, slave returns rdata=0xDEADBEEF after 2 cycles
//     -> rsp_data=0xDEADBEEF, rsp_resp=0, rsp_we=0.
//  4. rsp_ready held low 5 cycles
//     -> rsp_* stable, cmd_ready=0 throughout, new cmd accepted 1 cycle after
//        rsp_ready.
//  5. bresp=2 (SLVERR)
//     -> rsp_resp=2, err_count=1. With ERRCW=2, 5 errors -> err_count=3.
//  6. rst asserted in RD
//     -> next cycle all valids=0, rready=0, no response, cmd_ready=1 after
//        rst drops.

Source files
------------

// File: rtl/axil_cmd_master_if.sv
// rtl/axil_cmd_master_if.sv - command/response streams and AXI-Lite master channels for axil_cmd_master
interface axil_cmd_master_if #(
    parameter int CFGAW = 32,
    parameter int CFGDW = 32,
    parameter int ERRCW = 8
);
    logic [CFGAW-1:0] cmd_addr;
    logic [CFGDW-1:0] cmd_data;
    logic             cmd_we;
    logic             cmd_valid;
    logic             cmd_ready;

    logic [CFGDW-1:0] rsp_data;
    logic [1:0]       rsp_resp;
    logic             rsp_we;
    logic             rsp_valid;
    logic             rsp_ready;

    logic [CFGAW-1:0] m_axil_awaddr;
    logic             m_axil_awvalid;
    logic             m_axil_awready;
    logic [CFGDW-1:0] m_axil_wdata;
    logic             m_axil_wvalid;
    logic             m_axil_wready;
    logic [1:0]       m_axil_bresp;
    logic             m_axil_bvalid;
    logic             m_axil_bready;
    logic [CFGAW-1:0] m_axil_araddr;
    logic             m_axil_arvalid;
    logic             m_axil_arready;
    logic [CFGDW-1:0] m_axil_rdata;
    logic [1:0]       m_axil_rresp;
    logic             m_axil_rvalid;
    logic             m_axil_rready;

    logic [ERRCW-1:0] err_count;

    modport master (
        input  cmd_addr, cmd_data, cmd_we, cmd_valid, rsp_ready,
               m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
               m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        output cmd_ready, rsp_data, rsp_resp, rsp_we, rsp_valid,
               m_axil_awaddr, m_axil_awvalid, m_axil_wdata, m_axil_wvalid, m_axil_bready,
               m_axil_araddr, m_axil_arvalid, m_axil_rready, err_count
    );

    modport slave (
        output cmd_addr, cmd_data, cmd_we, cmd_valid, rsp_ready,
               m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
               m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        input  cmd_ready, rsp_data, rsp_resp, rsp_we, rsp_valid,
               m_axil_awaddr, m_axil_awvalid, m_axil_wdata, m_axil_wvalid, m_axil_bready,
               m_axil_araddr, m_axil_arvalid, m_axil_rready, err_count
    );
endinterface

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding AXI-Lite initiator driven by a command stream
module axil_cmd_master #(
    parameter int CFGAW = 32,
    parameter int CFGDW = 32,
    parameter int ERRCW = 8
) (
    input logic               clk,
    input logic               rst,
    axil_cmd_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

    state_t           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic             bready_q, bready_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [CFGAW-1:0] awaddr_q, awaddr_d;
    logic [CFGAW-1:0] araddr_q, araddr_d;
    logic [CFGDW-1:0] wdata_q, wdata_d;
    logic [CFGDW-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_resp_q, rsp_resp_d;
    logic             rsp_we_q, rsp_we_d;
    logic [ERRCW-1:0] err_q, err_d;
    logic             done;
    logic [1:0]       done_resp;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_we_d    = rsp_we_q;
        err_d       = err_q;
        done        = 1'b0;
        done_resp   = 2'b00;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (bus.cmd_we) begin
                        awaddr_d  = bus.cmd_addr;
                        wdata_d   = bus.cmd_data;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR;
                    end else begin
                        araddr_d  = bus.cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RA;
                    end
                end
            end
            WR: begin
                // Address and data handshakes complete independently, in either order.
                if (awvalid_q && bus.m_axil_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && bus.m_axil_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = WB;
                end
            end
            WB: begin
                if (bus.m_axil_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_data_d  = '0;
                    rsp_resp_d  = bus.m_axil_bresp;
                    rsp_we_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                    done        = 1'b1;
                    done_resp   = bus.m_axil_bresp;
                    state_d     = RSP;
                end
            end
            RA: begin
                if (bus.m_axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD;
                end
            end
            RD: begin
                if (bus.m_axil_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_data_d  = bus.m_axil_rdata;
                    rsp_resp_d  = bus.m_axil_rresp;
                    rsp_we_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    done        = 1'b1;
                    done_resp   = bus.m_axil_rresp;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase

        // Error count saturates at all-ones rather than wrapping.
        if (done && done_resp != 2'b00 && err_q != {ERRCW{1'b1}}) begin
            err_d = err_q + ERRCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= 2'b00;
            rsp_we_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_we_q    <= rsp_we_d;
            err_q       <= err_d;
        end
    end

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_resp       = rsp_resp_q;
    assign bus.rsp_we         = rsp_we_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.m_axil_awaddr  = awaddr_q;
    assign bus.m_axil_awvalid = awvalid_q;
    assign bus.m_axil_wdata   = wdata_q;
    assign bus.m_axil_wvalid  = wvalid_q;
    assign bus.m_axil_bready  = bready_q;
    assign bus.m_axil_araddr  = araddr_q;
    assign bus.m_axil_arvalid = arvalid_q;
    assign bus.m_axil_rready  = rready_q;
    assign bus.err_count      = err_q;
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - table, directed and randomized checks for axil_cmd_master
module tb_axil_cmd_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int EW = 2;
    localparam int ERR_MAX = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axil_cmd_master_if #(.CFGAW(AW), .CFGDW(DW), .ERRCW(EW)) bus ();
    axil_cmd_master #(.CFGAW(AW), .CFGDW(DW), .ERRCW(EW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed { logic [31:0] d; logic [1:0] r; logic w; } rsp_t;
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        int          aw, w, b, ar, r;
        logic [1:0]  resp;
        logic [31:0] xd;
        logic [1:0]  xr;
        bit          xw;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // slave configuration and state
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  cfg_resp;
    logic [31:0] smem [logic [31:0]];
    bit          aw_fire, w_fire, b_fire, ar_fire, r_fire;
    bit          aw_got, w_got, wr_pend, rd_pend;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    int          aw_hi, w_hi, b_win;
    bit          bready_prev;
    rsp_t        rsp_q [$];

    // reference model
    logic [31:0] ref_mem [logic [31:0]];
    int          err_exp;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            {aw_fire, w_fire, b_fire, ar_fire, r_fire} = '0;
            {aw_got, w_got, wr_pend, rd_pend} = '0;
            {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
            bus.m_axil_awready = 1'b0;
            bus.m_axil_wready  = 1'b0;
            bus.m_axil_arready = 1'b0;
            bus.m_axil_bvalid  = 1'b0;
            bus.m_axil_bresp   = 2'b00;
            bus.m_axil_rvalid  = 1'b0;
            bus.m_axil_rresp   = 2'b00;
            bus.m_axil_rdata   = '0;
            bready_prev = 1'b0;
        end else begin
            if (b_fire) begin bus.m_axil_bvalid = 1'b0; wr_pend = 1'b0; end
            if (r_fire) begin bus.m_axil_rvalid = 1'b0; rd_pend = 1'b0; end
            if (ar_fire) begin rd_pend = 1'b1; r_cnt = 0; end
            if (aw_fire) aw_got = 1'b1;
            if (w_fire) w_got = 1'b1;
            if (aw_got && w_got) begin
                smem[s_awaddr] = s_wdata;
                wr_pend = 1'b1; b_cnt = 0; aw_got = 1'b0; w_got = 1'b0;
            end
            if (bus.m_axil_awvalid) begin aw_cnt++; bus.m_axil_awready = (aw_cnt > aw_d); end
            else begin aw_cnt = 0; bus.m_axil_awready = 1'b0; end
            if (bus.m_axil_wvalid) begin w_cnt++; bus.m_axil_wready = (w_cnt > w_d); end
            else begin w_cnt = 0; bus.m_axil_wready = 1'b0; end
            if (bus.m_axil_arvalid) begin ar_cnt++; bus.m_axil_arready = (ar_cnt > ar_d); end
            else begin ar_cnt = 0; bus.m_axil_arready = 1'b0; end
            aw_fire = bus.m_axil_awvalid && bus.m_axil_awready;
            w_fire  = bus.m_axil_wvalid && bus.m_axil_wready;
            ar_fire = bus.m_axil_arvalid && bus.m_axil_arready;
            if (aw_fire) s_awaddr = bus.m_axil_awaddr;
            if (w_fire) s_wdata = bus.m_axil_wdata;
            if (ar_fire) s_araddr = bus.m_axil_araddr;
            if (wr_pend && !bus.m_axil_bvalid) begin
                b_cnt++;
                if (b_cnt > b_d) begin bus.m_axil_bvalid = 1'b1; bus.m_axil_bresp = cfg_resp; end
            end
            b_fire = bus.m_axil_bvalid && bus.m_axil_bready;
            if (rd_pend && !bus.m_axil_rvalid) begin
                r_cnt++;
                if (r_cnt > r_d) begin
                    bus.m_axil_rvalid = 1'b1;
                    bus.m_axil_rresp  = cfg_resp;
                    bus.m_axil_rdata  = smem.exists(s_araddr) ? smem[s_araddr] : dflt(s_araddr);
                end
            end
            r_fire = bus.m_axil_rvalid && bus.m_axil_rready;
            if (bus.m_axil_awvalid) aw_hi++;
            if (bus.m_axil_wvalid) w_hi++;
            if (bus.m_axil_bready && !bready_prev) b_win++;
            bready_prev = bus.m_axil_bready;
            if (bus.rsp_valid && bus.rsp_ready) rsp_q.push_back({bus.rsp_data, bus.rsp_resp, bus.rsp_we});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slave(input int a, input int w, input int b, input int ar, input int r, input logic [1:0] resp);
        aw_d = a; w_d = w; b_d = b; ar_d = ar; r_d = r; cfg_resp = resp;
    endtask

    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        bus.cmd_we = we; bus.cmd_addr = a; bus.cmd_data = d; bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 100) begin cyc(); n++; end
        if (n >= 100) timeout("cmd_accept");
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output rsp_t got, output bit ok);
        int n = 0;
        bus.rsp_ready = 1'b1;
        while (rsp_q.size() == 0 && n < 200) begin cyc(); n++; end
        bus.rsp_ready = 1'b0;
        if (rsp_q.size() == 0) begin timeout("rsp_wait"); ok = 1'b0; got = '0; end
        else begin got = rsp_q.pop_front(); ok = 1'b1; end
    endtask

    task automatic model_done(input bit we, input logic [31:0] a, input logic [31:0] d);
        if (we) ref_mem[a] = d;
        if (cfg_resp != 2'b00 && err_exp < ERR_MAX) err_exp++;
    endtask

    task automatic run_cmd(input bit we, input logic [31:0] a, input logic [31:0] d, output rsp_t got, output bit ok);
        issue(we, a, d);
        wait_rsp(got, ok);
        model_done(we, a, d);
    endtask

    vec_t tbl [10];

    initial begin
        rsp_t got;
        bit   ok;
        int   n;

        tbl[0] = '{1'b1, 32'h10,  32'hCAFE0001, 0, 0, 0, 0, 0, 2'd0, 32'h0,        2'd0, 1'b1};
        tbl[1] = '{1'b0, 32'h10,  32'h0,        0, 0, 0, 1, 0, 2'd0, 32'hCAFE0001, 2'd0, 1'b0};
        tbl[2] = '{1'b1, 32'h44,  32'h0BADF00D, 1, 1, 1, 0, 0, 2'd2, 32'h0,        2'd2, 1'b1};
        tbl[3] = '{1'b0, 32'h44,  32'h0,        0, 0, 0, 0, 1, 2'd3, 32'h0BADF00D, 2'd3, 1'b0};
        tbl[4] = '{1'b0, 32'd33,  32'h0,        0, 0, 0, 0, 2, 2'd0, 32'hDEADBEEF, 2'd0, 1'b0};
        tbl[5] = '{1'b1, 32'h3,   32'h1234,     0, 0, 0, 0, 0, 2'd0, 32'h0,        2'd0, 1'b1};
        tbl[6] = '{1'b0, 32'h3,   32'h0,        0, 0, 0, 2, 2, 2'd0, 32'h1234,     2'd0, 1'b0};
        tbl[7] = '{1'b1, 32'h8,   32'h55AA,     3, 1, 2, 0, 0, 2'd0, 32'h0,        2'd0, 1'b1};
        tbl[8] = '{1'b0, 32'h8,   32'h0,        0, 0, 0, 2, 0, 2'd1, 32'h55AA,     2'd1, 1'b0};
        tbl[9] = '{1'b0, 32'h100, 32'h0,        0, 0, 0, 0, 0, 2'd0, 32'h5A5A0100, 2'd0, 1'b0};

        smem[32'd33] = 32'hDEADBEEF;
        ref_mem[32'd33] = 32'hDEADBEEF;
        err_exp = 0;
        set_slave(0, 0, 0, 0, 0, 2'd0);
        rst = 1'b1;
        bus.cmd_addr = '0; bus.cmd_data = '0; bus.cmd_we = 1'b0; bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) cyc();

        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_awvalid", bus.m_axil_awvalid, 0);
        check("rst_wvalid", bus.m_axil_wvalid, 0);
        check("rst_arvalid", bus.m_axil_arvalid, 0);
        check("rst_bready", bus.m_axil_bready, 0);
        check("rst_rready", bus.m_axil_rready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_fields", {bus.rsp_data, bus.rsp_resp, bus.rsp_we}, 0);
        check("rst_addr_data", {bus.m_axil_awaddr, bus.m_axil_wdata, bus.m_axil_araddr}, 0);
        check("rst_err_count", bus.err_count, 0);
        rst = 1'b0;
        cyc();

        // write with every ready immediate: valids at accept+1, bready at accept+2
        issue(1'b1, 32'h3, 32'h1234);
        check("t1_awvalid", bus.m_axil_awvalid, 1);
        check("t1_wvalid", bus.m_axil_wvalid, 1);
        check("t1_bready_early", bus.m_axil_bready, 0);
        check("t1_awaddr", bus.m_axil_awaddr, 32'h3);
        check("t1_wdata", bus.m_axil_wdata, 32'h1234);
        cyc();
        check("t1_bready", bus.m_axil_bready, 1);
        check("t1_valids_low", {bus.m_axil_awvalid, bus.m_axil_wvalid}, 0);
        wait_rsp(got, ok);
        model_done(1'b1, 32'h3, 32'h1234);
        if (ok) check("t1_rsp", got, {32'h0, 2'd0, 1'b1});

        // awready late by 3 cycles, wready immediate
        set_slave(3, 0, 0, 0, 0, 2'd0);
        aw_hi = 0; w_hi = 0; b_win = 0;
        run_cmd(1'b1, 32'h8, 32'h55AA, got, ok);
        check("t2_aw_cycles", aw_hi, 4);
        check("t2_w_cycles", w_hi, 1);
        check("t2_b_windows", b_win, 1);
        if (ok) check("t2_rsp", got, {32'h0, 2'd0, 1'b1});
        check("t2_extra_rsp", rsp_q.size(), 0);

        for (int i = 0; i < 10; i++) begin
            set_slave(tbl[i].aw, tbl[i].w, tbl[i].b, tbl[i].ar, tbl[i].r, tbl[i].resp);
            run_cmd(tbl[i].we, tbl[i].addr, tbl[i].data, got, ok);
            if (ok) begin
                check($sformatf("tbl%0d_data", i), got.d, tbl[i].xd);
                check($sformatf("tbl%0d_resp", i), got.r, tbl[i].xr);
                check($sformatf("tbl%0d_we", i), got.w, tbl[i].xw);
            end
            check($sformatf("tbl%0d_err", i), bus.err_count, err_exp);
        end

        // response back-pressure for 5 cycles with the next command already waiting
        set_slave(0, 0, 0, 0, 0, 2'd0);
        issue(1'b0, 32'h3, 32'h0);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin cyc(); n++; end
        if (n >= 50) timeout("t4_rsp_valid");
        bus.cmd_we = 1'b1; bus.cmd_addr = 32'h60; bus.cmd_data = 32'hA5; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_hold%0d_rsp", i), {bus.rsp_valid, bus.rsp_data, bus.rsp_resp, bus.rsp_we},
                  {1'b1, exp_rd(32'h3), 2'd0, 1'b0});
            check($sformatf("t4_hold%0d_cmd_ready", i), bus.cmd_ready, 0);
            cyc();
        end
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        check("t4_cmd_ready_after", bus.cmd_ready, 1);
        check("t4_rsp_valid_after", bus.rsp_valid, 0);
        check("t4_rsp_count", rsp_q.size(), 1);
        if (rsp_q.size() != 0) void'(rsp_q.pop_front());
        model_done(1'b0, 32'h3, 32'h0);
        cyc();
        bus.cmd_valid = 1'b0;
        check("t4_accepted", {bus.m_axil_awvalid, bus.cmd_ready}, 2'b10);
        wait_rsp(got, ok);
        model_done(1'b1, 32'h60, 32'hA5);
        if (ok) check("t4_wr_rsp", got, {32'h0, 2'd0, 1'b1});

        // randomized traffic against the reference memory and error counter
        for (int i = 0; i < 40; i++) begin
            bit          we;
            logic [31:0] a, d;
            logic [1:0]  resp;
            we   = 1'($urandom_range(0, 1));
            a    = 32'($urandom_range(0, 15) * 4);
            d    = $urandom;
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), resp);
            issue(we, a, d);
            repeat ($urandom_range(0, 3)) cyc();
            wait_rsp(got, ok);
            model_done(we, a, d);
            if (ok) check($sformatf("rnd%0d_rsp", i), got, {(we ? 32'h0 : exp_rd(a)), resp, we});
            check($sformatf("rnd%0d_err", i), bus.err_count, err_exp);
        end

        // reset while waiting in RD abandons the read
        set_slave(0, 0, 0, 0, 10, 2'd0);
        issue(1'b0, 32'h10, 32'h0);
        n = 0;
        while (!bus.m_axil_rready && n < 50) begin cyc(); n++; end
        if (n >= 50) timeout("t6_rready");
        cyc();
        rst = 1'b1;
        cyc();
        check("t6_valids", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid, bus.rsp_valid}, 0);
        check("t6_readies", {bus.m_axil_bready, bus.m_axil_rready}, 0);
        check("t6_err", bus.err_count, 0);
        rst = 1'b0;
        rsp_q.delete();
        err_exp = 0;
        cyc();
        check("t6_cmd_ready", bus.cmd_ready, 1);
        bus.rsp_ready = 1'b1;
        repeat (15) cyc();
        bus.rsp_ready = 1'b0;
        check("t6_no_rsp", rsp_q.size(), 0);

        // SLVERR completions: counter climbs to 3 and stays there
        set_slave(0, 0, 0, 0, 0, 2'd2);
        for (int i = 0; i < 5; i++) begin
            run_cmd(1'b1, 32'h80 + 32'(i * 4), 32'(i), got, ok);
            if (ok) check($sformatf("t5_resp%0d", i), got.r, 2'd2);
            check($sformatf("t5_err%0d", i), bus.err_count, err_exp);
        end
        check("t5_err_sat", bus.err_count, ERR_MAX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
